// File: rtl/cmd_exec_sync_if.sv
// Command handshake between the command-memory writer (master) and the executor (slave).
// The writer presents a full command with a one-cycle DATA_WR strobe; REQ_COMM asks it for the next one.
interface cmd_exec_sync_if;
    logic        DATA_WR;
    logic [47:0] FREQ;
    logic [47:0] FREQ_STEP;
    logic [31:0] FREQ_RATE;
    logic [63:0] TIME_START;
    logic [15:0] N_impulse;
    logic [1:0]  TYPE_impulse;
    logic [31:0] Interval_Ti;
    logic [31:0] Interval_Tp;
    logic [31:0] Tblank1;
    logic [31:0] Tblank2;
    logic        REQ_COMM;

    modport master (
        output DATA_WR, FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse,
               TYPE_impulse, Interval_Ti, Interval_Tp, Tblank1, Tblank2,
        input  REQ_COMM
    );

    modport slave (
        input  DATA_WR, FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse,
               TYPE_impulse, Interval_Ti, Interval_Tp, Tblank1, Tblank2,
        output REQ_COMM
    );
endinterface

// File: rtl/cmd_exec_sync.sv
// Executes timed pulse bursts (IMP/BLANK gates, NCO frequency law) and requests the next command.
// All outputs registered, one cycle after the deciding edge; commands arriving mid-burst wait in a one-deep pending slot.
module cmd_exec_sync #(
    parameter int REQ_LEN = 4,
    parameter int CNT_W   = 32
) (
    input  logic           CLK,
    input  logic           rst,
    input  logic [63:0]    TIME,
    cmd_exec_sync_if.slave cmd,
    output logic           IMP,
    output logic           BLANK,
    output logic [47:0]    NCO_FREQ,
    output logic           BUSY,
    output logic           LATE
);
    localparam int RW = $clog2(REQ_LEN);

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] step;
        logic [31:0] rate;
        logic [63:0] tstart;
        logic [15:0] n;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PULSE, S_REQ} state_t;

    state_t           state_q, state_d;
    cmd_t             act_q, act_d, pend_q, pend_d, wr_cmd;
    logic             pend_vld_q, pend_vld_d, first_q, first_d;
    logic [CNT_W-1:0] pc_q, pc_d, rc_q, rc_d;
    logic [15:0]      idx_q, idx_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic             imp_q, imp_d, blank_q, blank_d, req_q, req_d;
    logic             busy_q, busy_d, late_q, late_d;
    logic [47:0]      nco_q, nco_d;
    logic [CNT_W-1:0] ti_c, tb1_c, tb2_c, tp_m1, rate_m1, pc_nx;

    assign wr_cmd = '{freq: cmd.FREQ, step: cmd.FREQ_STEP, rate: cmd.FREQ_RATE,
                      tstart: cmd.TIME_START, n: cmd.N_impulse, typ: cmd.TYPE_impulse,
                      ti: cmd.Interval_Ti, tp: cmd.Interval_Tp, tb1: cmd.Tblank1, tb2: cmd.Tblank2};

    assign ti_c    = CNT_W'(act_q.ti);
    assign tb1_c   = CNT_W'(act_q.tb1);
    assign tb2_c   = CNT_W'(act_q.tb2);
    // Zero period / zero rate behave as one cycle.
    assign tp_m1   = (act_q.tp == '0)   ? '0 : CNT_W'(act_q.tp) - CNT_W'(1);
    assign rate_m1 = (act_q.rate == '0) ? '0 : CNT_W'(act_q.rate) - CNT_W'(1);
    assign pc_nx   = pc_q + CNT_W'(1);

    // Blank windows: leading Tblank1 and Tblank2 after IMP falls; period end clips both.
    function automatic logic blank_at(input logic [CNT_W-1:0] p, ti, tb1, tb2);
        return (p < tb1) || ((p >= ti) && ((p - ti) < tb2));
    endfunction

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        first_d    = first_q;
        pc_d       = pc_q;
        rc_d       = rc_q;
        idx_d      = idx_q;
        rcnt_d     = rcnt_q;
        imp_d      = 1'b0;
        blank_d    = 1'b0;
        req_d      = 1'b0;
        late_d     = 1'b0;
        busy_d     = busy_q;
        nco_d      = nco_q;
        case (state_q)
            S_IDLE: begin
                if (cmd.DATA_WR) begin
                    act_d   = wr_cmd;
                    state_d = S_ARMED;
                    first_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_ARMED: begin
                if (cmd.DATA_WR) begin
                    act_d = wr_cmd;
                end else if (TIME >= act_q.tstart) begin
                    late_d  = first_q;
                    first_d = 1'b0;
                    idx_d   = '0;
                    pc_d    = '0;
                    rc_d    = '0;
                    nco_d   = act_q.freq;
                    if (act_q.n == '0) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        state_d = S_PULSE;
                        imp_d   = (ti_c != '0);
                        blank_d = blank_at('0, ti_c, tb1_c, tb2_c);
                    end
                end else begin
                    first_d = 1'b0;
                end
            end
            S_PULSE: begin
                if (cmd.DATA_WR) begin
                    pend_d     = wr_cmd;
                    pend_vld_d = 1'b1;
                end
                if (act_q.typ == 2'd1 && imp_q) begin
                    if (rc_q == rate_m1) begin
                        rc_d  = '0;
                        nco_d = nco_q + act_q.step;
                    end else begin
                        rc_d = rc_q + CNT_W'(1);
                    end
                end
                if (pc_q == tp_m1) begin
                    if (idx_q == act_q.n - 16'd1) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        pc_d    = '0;
                        rc_d    = '0;
                        imp_d   = (ti_c != '0);
                        blank_d = blank_at('0, ti_c, tb1_c, tb2_c);
                        if (act_q.typ == 2'd1) begin
                            nco_d = act_q.freq;
                        end else if (act_q.typ == 2'd2) begin
                            nco_d = nco_q + act_q.step;
                        end
                    end
                end else begin
                    pc_d    = pc_nx;
                    imp_d   = (pc_nx < ti_c);
                    blank_d = blank_at(pc_nx, ti_c, tb1_c, tb2_c);
                end
            end
            S_REQ: begin
                req_d = 1'b1;
                if (rcnt_q == RW'(REQ_LEN - 1)) begin
                    req_d   = 1'b0;
                    rcnt_d  = '0;
                    first_d = 1'b1;
                    // A strobe on the final REQ cycle is the newest command and goes straight to active.
                    if (cmd.DATA_WR) begin
                        act_d      = wr_cmd;
                        pend_vld_d = 1'b0;
                        state_d    = S_ARMED;
                    end else if (pend_vld_q) begin
                        act_d      = pend_q;
                        pend_vld_d = 1'b0;
                        state_d    = S_ARMED;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                    if (cmd.DATA_WR) begin
                        pend_d     = wr_cmd;
                        pend_vld_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= S_IDLE;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            first_q    <= 1'b0;
            pc_q       <= '0;
            rc_q       <= '0;
            idx_q      <= '0;
            rcnt_q     <= '0;
            imp_q      <= 1'b0;
            blank_q    <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            late_q     <= 1'b0;
            nco_q      <= '0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            first_q    <= first_d;
            pc_q       <= pc_d;
            rc_q       <= rc_d;
            idx_q      <= idx_d;
            rcnt_q     <= rcnt_d;
            imp_q      <= imp_d;
            blank_q    <= blank_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            late_q     <= late_d;
            nco_q      <= nco_d;
        end
    end

    assign IMP          = imp_q;
    assign BLANK        = blank_q;
    assign NCO_FREQ     = nco_q;
    assign BUSY         = busy_q;
    assign LATE         = late_q;
    assign cmd.REQ_COMM = req_q;
endmodule

// File: tb/tb_cmd_exec_sync.sv
// Bench for cmd_exec_sync: directed scenarios plus random commands checked cycle by cycle
// against an arithmetic model of the burst timeline.
module tb_cmd_exec_sync;
    localparam int REQ_LEN = 4;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] step;
        logic [31:0] rate;
        logic [63:0] tstart;
        logic [15:0] n;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } tcmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] time_in = '0;
    logic        imp, blank, busy, late;
    logic [47:0] nco;

    cmd_exec_sync_if cif();

    cmd_exec_sync #(.REQ_LEN(REQ_LEN), .CNT_W(32)) dut (
        .CLK(clk), .rst(rst), .TIME(time_in), .cmd(cif),
        .IMP(imp), .BLANK(blank), .NCO_FREQ(nco), .BUSY(busy), .LATE(late)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] t_last = '0;
    logic [47:0] nco_hold = '0;

    // One clock: inputs presented before the posedge, outputs sampled at the following negedge.
    task automatic tick(input bit wr, input tcmd_t c);
        cif.DATA_WR      = wr;
        cif.FREQ         = c.freq;
        cif.FREQ_STEP    = c.step;
        cif.FREQ_RATE    = c.rate;
        cif.TIME_START   = c.tstart;
        cif.N_impulse    = c.n;
        cif.TYPE_impulse = c.typ;
        cif.Interval_Ti  = c.ti;
        cif.Interval_Tp  = c.tp;
        cif.Tblank1      = c.tb1;
        cif.Tblank2      = c.tb2;
        @(posedge clk);
        t_last = time_in;
        @(negedge clk);
        time_in = time_in + 64'd1;
        cif.DATA_WR = 1'b0;
    endtask

    function automatic logic [52:0] vec(input bit i, b, rq, bs, lt, input logic [47:0] n);
        return {i, b, rq, bs, lt, n};
    endfunction

    task automatic check(input string tag, input logic [52:0] exp_v);
        logic [52:0] obs;
        obs = {imp, blank, cif.REQ_COMM, busy, late, nco};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s time=%0d observed{imp,blank,req,busy,late,nco}=%h expected=%h",
                   tag, t_last, obs, exp_v);
        end
    endtask

    // Frequency at position p of pulse i (p may be one past the period end for the held value).
    function automatic logic [47:0] nco_at(input tcmd_t c, input longint i, input longint p);
        longint re = (c.rate == 0) ? 1 : longint'(c.rate);
        longint ti = longint'(c.ti);
        logic [47:0] mul;
        case (c.typ)
            2'd1: begin
                mul = c.step * 48'(((p < ti) ? p : ti) / re);
                return c.freq + mul;
            end
            2'd2: begin
                mul = c.step * 48'(i);
                return c.freq + mul;
            end
            default: return c.freq;
        endcase
    endfunction

    function automatic logic [52:0] burst_vec(input tcmd_t c, input longint r, input bit lt);
        longint tpe = (c.tp == 0) ? 1 : longint'(c.tp);
        longint j = r - 1;
        longint i = j / tpe;
        longint p = j % tpe;
        longint ti = longint'(c.ti);
        longint tb1 = longint'(c.tb1);
        longint tb2 = longint'(c.tb2);
        bit e_imp = (p < ti);
        bit e_blank = (p < tb1) || ((p >= ti) && (p - ti < tb2));
        return vec(e_imp, e_blank, 1'b0, 1'b1, lt, nco_at(c, i, p));
    endfunction

    // Called right after the edge that made c active; follows it through burst and REQ to the exit edge.
    task automatic run_cmd(input string tag, input tcmd_t c, input bit pend_en, input longint pend_q,
                           input tcmd_t pc, input bit dec_en, input tcmd_t dc);
        logic [63:0] t0 = t_last;
        longint tpe = (c.tp == 0) ? 1 : longint'(c.tp);
        longint L = longint'(c.n) * tpe;
        longint k;
        longint r;
        logic [47:0] hold;
        tcmd_t d;
        bit wr;
        bit lt;
        k = (c.tstart <= t0 + 64'd1) ? 1 : longint'(c.tstart - t0);
        hold = (c.n == 0) ? c.freq : nco_at(c, longint'(c.n) - 1, tpe);
        check({tag, "/arm0"}, vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, nco_hold));
        for (longint m = 1; m <= k + L + REQ_LEN; m++) begin
            wr = 1'b0;
            d = '0;
            if (pend_en && (m - k == pend_q)) begin
                wr = 1'b1;
                d = pc;
            end else if (pend_en && dec_en && (m - k == pend_q - 1)) begin
                wr = 1'b1;
                d = dc;
            end
            tick(wr, d);
            r = m - k + 1;
            lt = (r == 1) && (k == 1);
            if (m < k)
                check({tag, "/armed"}, vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, nco_hold));
            else if (r <= L)
                check({tag, "/burst"}, burst_vec(c, r, lt));
            else if (r <= L + REQ_LEN)
                check({tag, "/req"}, vec(1'b0, 1'b0, 1'b1, 1'b1, lt, hold));
            else
                check({tag, "/exit"}, vec(1'b0, 1'b0, 1'b0, pend_en, 1'b0, hold));
        end
        nco_hold = hold;
    endtask

    function automatic tcmd_t rnd_cmd(input logic [63:0] tnow);
        tcmd_t c;
        c.freq   = {16'($urandom), $urandom};
        c.step   = {16'($urandom), $urandom};
        c.rate   = $urandom_range(0, 4);
        c.n      = 16'($urandom_range(0, 4));
        c.typ    = 2'($urandom_range(0, 3));
        c.ti     = $urandom_range(1, 12);
        c.tp     = $urandom_range(0, 15);
        c.tb1    = $urandom_range(0, 6);
        c.tb2    = $urandom_range(0, 8);
        c.tstart = ($urandom_range(0, 3) == 0) ? tnow - 64'($urandom_range(0, 5))
                                               : tnow + 64'($urandom_range(2, 40));
        return c;
    endfunction

    initial begin
        tcmd_t none, c, c2, pc, dc;
        longint L, pq;
        bit pe, de;
        none = '0;
        cif.DATA_WR = 1'b0;

        // Reset state
        tick(1'b0, none);
        tick(1'b0, none);
        check("reset", vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0));
        rst = 1'b0;
        tick(1'b0, none);
        check("idle", vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0));

        // Basic burst starting at TIME=1000
        c = '0; c.tstart = 64'd1000; c.n = 16'd3; c.ti = 32'd10; c.tp = 32'd50; c.freq = 48'h1234;
        tick(1'b1, c);
        run_cmd("basic", c, 1'b0, 0, none, 1'b0, none);

        // Chirp
        c = '0; c.typ = 2'd1; c.freq = 48'd100; c.step = 48'd5; c.rate = 32'd3; c.ti = 32'd9;
        c.tp = 32'd12; c.n = 16'd1; c.tstart = t_last + 64'd6;
        tick(1'b1, c);
        run_cmd("chirp", c, 1'b0, 0, none, 1'b0, none);

        // Stepped with wrap
        c = '0; c.typ = 2'd2; c.freq = 48'hFFFF_FFFF_FFFE; c.step = 48'd1; c.ti = 32'd3;
        c.tp = 32'd6; c.n = 16'd4; c.tstart = t_last + 64'd4;
        tick(1'b1, c);
        run_cmd("stepped", c, 1'b0, 0, none, 1'b0, none);

        // Late start, then N=0
        c = '0; c.tstart = 64'd5; c.n = 16'd2; c.ti = 32'd4; c.tp = 32'd7; c.freq = 48'hABC;
        tick(1'b1, c);
        run_cmd("late", c, 1'b0, 0, none, 1'b0, none);
        c = '0; c.tstart = t_last + 64'd5; c.n = 16'd0; c.ti = 32'd4; c.tp = 32'd7; c.freq = 48'h55;
        tick(1'b1, c);
        run_cmd("n0", c, 1'b0, 0, none, 1'b0, none);

        // Blanking with overlap
        c = '0; c.ti = 32'd10; c.tp = 32'd20; c.tb1 = 32'd3; c.tb2 = 32'd15; c.n = 16'd2;
        c.freq = 48'h9; c.tstart = t_last + 64'd3;
        tick(1'b1, c);
        run_cmd("blank", c, 1'b0, 0, none, 1'b0, none);

        // Replacement while armed
        c = '0; c.n = 16'd2; c.ti = 32'd2; c.tp = 32'd3; c.freq = 48'h111; c.tstart = t_last + 64'd200;
        tick(1'b1, c);
        check("repl/arm", vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, nco_hold));
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, none);
            check("repl/wait", vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, nco_hold));
        end
        c2 = '0; c2.n = 16'd1; c2.ti = 32'd5; c2.tp = 32'd6; c2.freq = 48'h222; c2.tstart = t_last + 64'd10;
        tick(1'b1, c2);
        run_cmd("repl", c2, 1'b0, 0, none, 1'b0, none);

        // Pending during PULSE, overwritten once, runs without returning to IDLE
        c = '0; c.n = 16'd2; c.ti = 32'd3; c.tp = 32'd5; c.freq = 48'h300; c.tstart = t_last + 64'd3;
        dc = '0; dc.n = 16'd3; dc.ti = 32'd1; dc.tp = 32'd2; dc.freq = 48'hDEAD; dc.tstart = 64'd0;
        pc = '0; pc.n = 16'd1; pc.ti = 32'd2; pc.tp = 32'd4; pc.freq = 48'h400; pc.tstart = 64'd0;
        tick(1'b1, c);
        run_cmd("pend", c, 1'b1, 3, pc, 1'b1, dc);
        run_cmd("pend2", pc, 1'b0, 0, none, 1'b0, none);

        // Reset in the middle of a burst
        c = '0; c.typ = 2'd2; c.n = 16'd3; c.ti = 32'd5; c.tp = 32'd8; c.freq = 48'h77; c.step = 48'h3;
        c.tstart = t_last + 64'd4;
        tick(1'b1, c);
        for (int m = 1; m <= 4; m++) tick(1'b0, none);
        check("rst/pulse", burst_vec(c, 2, 1'b0));
        rst = 1'b1;
        tick(1'b0, none);
        check("rst/now", vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0));
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, none);
            check("rst/after", vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0));
        end
        nco_hold = '0;

        // Random commands with optional pending/overwrite
        for (int it = 0; it < 16; it++) begin
            c  = rnd_cmd(t_last);
            pc = rnd_cmd(t_last + 64'd30);
            dc = rnd_cmd(t_last);
            L  = longint'(c.n) * ((c.tp == 0) ? 1 : longint'(c.tp));
            pe = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            pq = longint'($urandom_range(2, 32'(L + REQ_LEN)));
            tick(1'b1, c);
            run_cmd("rnd", c, pe, pq, pc, de, dc);
            if (pe) run_cmd("rnd_pend", pc, 1'b0, 0, none, 1'b0, none);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cmd_exec_sync.md
Name: cmd_exec_sync

Overview:
- Synchronisation/execution block: the consumer end of the command interface driven by the command-memory writer.
- Latches a command on DATA_WR and waits until system TIME reaches TIME_START.
- Then generates a burst of N_impulse pulses with blanking gates and a programmed frequency law.
- On completion, raises REQ_COMM so the writer retires the command and supplies the next one.

Parameters:
REQ_LEN, 4, REQ_COMM pulse length in CLK cycles; minimum 3, required by the writer's 3-stage edge detector.
CNT_W, 32, width of the interval/blank/rate counters.

Ports:
CLK  in  1  system clock, 48 MHz
rst  in  1  synchronous, active-high reset
TIME  in  64  system time in CLK ticks
DATA_WR  in  1  command strobe; fields are valid in the same cycle
FREQ  in  48  start frequency word
FREQ_STEP  in  48  frequency increment
FREQ_RATE  in  32  cycles between in-pulse increments
TIME_START  in  64  execution time
N_impulse  in  16  pulse count
TYPE_impulse  in  2  frequency law
Interval_Ti  in  32  pulse width, cycles
Interval_Tp  in  32  pulse period, cycles
Tblank1  in  32  blank length from pulse start
Tblank2  in  32  blank length after pulse end
REQ_COMM  out  1  next-command request, REQ_LEN cycles high
IMP  out  1  pulse gate
BLANK  out  1  receiver blanking gate
NCO_FREQ  out  48  frequency word to NCO
BUSY  out  1  command held or executing
LATE  out  1  one-cycle flag: command started late

Behaviour:
- Reset: all outputs are 0, including NCO_FREQ. State goes to IDLE; active and pending registers are cleared. Reset mid-burst aborts the burst immediately and no REQ_COMM is issued.
- All outputs are registered.
- States: IDLE, ARMED, PULSE, REQ.
- IDLE:
  - DATA_WR latches all fields into the active register and moves to ARMED.
  - BUSY=1 from the next cycle.
- ARMED:
  - DATA_WR replaces the active command and stays in ARMED. A new command takes priority over a same-cycle time match; the compare is redone next cycle.
  - The compare is TIME >= TIME_START, unsigned 64-bit.
  - If the compare is true on the first ARMED cycle, LATE=1 for one cycle and execution still starts.
  - On a match in cycle k: IMP=1 at k+1, BLANK=1 at k+1 if Tblank1>0, and the pulse index is reset to 0.
  - If N_impulse==0: no pulse; go to REQ at k+1.
- PULSE, per period of Interval_Tp cycles, with the period counter starting at the pulse's first cycle:
  - IMP high for min(Ti,Tp) cycles. Ti=0 gives no IMP.
  - BLANK high for the first Tblank1 cycles, and for Tblank2 cycles immediately after IMP falls. Both windows are clipped at the period end.
  - Tp=0 is treated as 1.
  - At the period end: if index==N_impulse-1, go to REQ; otherwise increment the index and start the next period in the next cycle, with no idle cycle.
- Frequency law, 48-bit modular arithmetic, wraps silently:
  - TYPE 0 or 3: NCO_FREQ=FREQ for the whole burst.
  - TYPE 1 (chirp): NCO_FREQ=FREQ at each pulse start; +FREQ_STEP every FREQ_RATE cycles while IMP=1. FREQ_RATE=0 is treated as 1.
  - TYPE 2 (stepped): NCO_FREQ=FREQ+index*FREQ_STEP, updated at each pulse start by accumulation, not multiplication.
  - NCO_FREQ holds its last value after the burst.
- DATA_WR during PULSE:
  - The command is stored in a one-deep pending register; a later DATA_WR overwrites it.
  - The active burst is never disturbed.
- REQ:
  - REQ_COMM=1 for REQ_LEN cycles; IMP=0 and BLANK=0.
  - Then go to ARMED if pending is valid (pending moves to active and pending is cleared), else to IDLE with BUSY=0.
  - DATA_WR during REQ is captured as pending.
- TIME jumps backwards (clock re-set) while ARMED: the block simply keeps comparing. There is no timeout.

Test Plan:
- Basic burst: reset, then DATA_WR with TIME_START=1000, N=3, Ti=10, Tp=50, TYPE 0, FREQ=0x1234, Tblank1=Tblank2=0, while TIME counts from 0.
  - IMP rises at TIME=1001, 1051 and 1101, 10 cycles each.
  - REQ_COMM is high 4 cycles starting the cycle after the 150th period cycle.
  - NCO_FREQ=0x1234 throughout; BUSY then falls.
- Chirp: TYPE 1, FREQ=100, STEP=5, RATE=3, Ti=9, N=1.
  - NCO_FREQ runs 100, 105, 110, 115 across the pulse and holds 115 afterwards.
- Stepped with wrap: TYPE 2, FREQ=0xFFFF_FFFF_FFFE, STEP=1, N=4.
  - NCO_FREQ at the pulse starts is ...FFFE, ...FFFF, 0, 1.
- Late start and N=0: a command with TIME_START=5 loaded at TIME=100 gives LATE=1 for one cycle, then the burst runs. A command with N=0 gives no IMP, only REQ_COMM.
- Blanking with overlap: Ti=10, Tp=20, Tblank1=3, Tblank2=15.
  - BLANK is high for 3 cycles, low for 7, then high for 10 (clipped at the period end).
- Replacement, pending and reset:
  - DATA_WR in ARMED replaces the command; only the second one executes.
  - DATA_WR during PULSE executes after REQ_COMM without returning to IDLE.
  - rst asserted mid-PULSE gives all outputs 0 the next cycle and no REQ_COMM.
